fc_argmax_layer: RTL and testbench
==================================

Name: fc_argmax_layer

Overview:
- Parametrised fully-connected classifier layer with an internal weight/bias store, a LANES-wide MAC datapath and a streaming argmax.
- Sits at the tail of the CNN pipeline: consumes the flattened activation stream from the last pooling layer and emits a predicted label plus its winning score.
- Unlike the previous fixed layer, widths, class count and lane count are parameters, and the weights can be reloaded at runtime between images.

Parameters:
- ACT_W, 8, signed activation width
- WGT_W, 8, signed weight width
- BIAS_W, 16, signed bias width; also the weight-stream beat width
- LANES, 16, activations per input beat and MACs per cycle
- N_IN, 256, input features; must be a multiple of LANES
- N_OUT, 10, number of classes; 2..255
- ACC_W, 32, accumulator and score width
- LABEL_W, 8, label width

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- a_Data_TDATA  in  LANES*ACT_W  activation beat; lane 0 is in the LSBs and is the lowest feature index
- a_Data_TVALID  in  1  activation valid
- a_Data_TREADY  out  1  activation ready
- weight_TDATA  in  BIAS_W  bias or weight beat; a weight occupies bits [WGT_W-1:0]
- weight_TVALID  in  1  weight valid
- weight_TREADY  out  1  weight ready
- reload_req  in  1  level request to reload weights
- pre_label_TDATA  out  LABEL_W  argmax class index
- pre_label_TVALID  out  1  result valid
- pre_label_TREADY  in  1  result ready
- pre_score_out  out  ACC_W  winning score; valid while pre_label_TVALID is high
- weights_loaded  out  1  high once a complete weight set is stored

Behaviour:
- Reset (async assert, sync release) values:
  - State is LOAD_B.
  - All TREADY/TVALID outputs are 0.
  - pre_label_TDATA, pre_score_out and weights_loaded are 0.
  - Counters and the activation buffer are cleared.
  - Weight RAM contents are not cleared.
- Transfer rule: a beat transfers when TVALID && TREADY on a rising edge.
- Constant: BEATS = N_IN/LANES.
- LOAD_B:
  - weight_TREADY = 1.
  - Accepts N_OUT bias beats; bias k goes to class k.
  - After N_OUT beats go to LOAD_W.
- LOAD_W:
  - weight_TREADY = 1.
  - Accepts N_OUT*N_IN weights, class-major then feature order.
  - Every LANES weights are packed into one RAM word (address = class*BEATS + beat).
  - After the last weight: weights_loaded <= 1, go to COLLECT.
- COLLECT:
  - a_Data_TREADY = 1.
  - Stores BEATS beats into the activation buffer, then goes to COMPUTE.
  - If reload_req = 1 while zero beats are collected: weights_loaded <= 0, go to LOAD_B (this has priority over a simultaneous a_Data beat, which is not accepted).
  - reload_req is ignored mid-image.
- COMPUTE:
  - All ready signals are 0.
  - Per cycle, one RAM word is multiplied against one buffer slice in LANES signed multipliers.
  - Pipeline: stage 1 registers the products; stage 2 forms the adder-tree sum and accumulates.
  - The accumulator is seeded with the sign-extended bias at the first beat of each class.
  - Exact length: N_OUT*BEATS + 3 cycles.
  - ACC_W is chosen so no overflow is possible; no saturation is applied.
- Argmax:
  - Updates as each class sum completes.
  - A candidate replaces the current best only if strictly greater, so ties resolve to the lowest index.
  - Class 0 initialises the best.
- OUTPUT:
  - pre_label_TVALID = 1; label and score are held stable until pre_label_TREADY.
  - On the handshake go to COLLECT with TVALID = 0 in the same edge's next state.
  - TREADY low indefinitely stalls; no data loss.
- Reset mid-operation: returns to LOAD_B; a full reload is required.

Decomposition:
- Shared package fc_pkg: state enum (LOAD_B, LOAD_W, COLLECT, COMPUTE, OUTPUT), BEATS/address-width localparam functions, signed-extend helper.
- One sub-module, fc_mac_lanes: LANES multipliers, registered products, pipelined adder tree, with a fixed 2-cycle latency.
- Weight RAM is inferred inline.

Test Plan:
- Bias 0..9, all weights 1, activations all 1 -> label 9, score 265, TVALID after exactly N_OUT*16+3 COMPUTE cycles.
- All biases 0, weights of class 3 = 2 and others 1, activations 1 -> label 3, score 512.
- Tie: biases 5 for classes 2 and 7, all weights 0 -> label 2, score 5.
- Negative values: activations -1, class 0 weights +1 and others -1, biases 0 -> label 1, score 256, pre_score_out = 0x00000100.
- Hold pre_label_TREADY low for 20 cycles -> TVALID, label and score stable, a_Data_TREADY 0; after the release the next image is accepted.
- reload_req in idle COLLECT with a new set (class 4 biased 100) -> weights_loaded drops then rises, next label 4.
- Reset asserted mid-COMPUTE -> all outputs are 0 immediately, state is LOAD_B, weight_TREADY is 1 after release.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and helper functions for the fully-connected argmax classifier layer.
package fc_pkg;

    typedef enum logic [2:0] {
        LOAD_B  = 3'd0,
        LOAD_W  = 3'd1,
        COLLECT = 3'd2,
        COMPUTE = 3'd3,
        OUTPUT  = 3'd4
    } fc_state_e;

    // Number of activation beats per image
    function automatic int calcBeats(input int nIn, input int lanes);
        return nIn / lanes;
    endfunction

    // Counter/address width for a given depth, never narrower than one bit
    function automatic int addrWidth(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Sign-extend the low 'width' bits of value to the full 64 bits
    function automatic logic [63:0] signExtend(input logic [63:0] value, input int width);
        return 64'($signed(value << (64 - width)) >>> (64 - width));
    endfunction

endpackage

// File: rtl/fc_mac_lanes.sv
// LANES signed multipliers followed by a registered adder tree; fixed two-cycle latency.
module fc_mac_lanes #(
    parameter int LANES = 16,
    parameter int ACT_W = 8,
    parameter int WGT_W = 8,
    parameter int SUM_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [LANES*ACT_W-1:0]   act_i,
    input  logic [LANES*WGT_W-1:0]   wgt_i,
    output logic signed [SUM_W-1:0]  sum_o
);

    localparam int PROD_W = ACT_W + WGT_W;

    logic signed [PROD_W-1:0] prod_d [LANES];
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic signed [SUM_W-1:0]  sum_d;

    // Per-lane signed products of one activation slice and one weight word
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = $signed(act_i[i*ACT_W +: ACT_W]) * $signed(wgt_i[i*WGT_W +: WGT_W]);
        end
    end

    // Stage 1: register the products
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    // Adder tree over the registered products, each sign-extended to the sum width
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end
    end

    // Stage 2: register the lane sum
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_o <= '0;
        end else begin
            sum_o <= sum_d;
        end
    end

endmodule

// File: rtl/fc_argmax_layer.sv
// Fully-connected classifier layer: runtime-loadable weights/biases, LANES-wide MAC, streaming argmax.
module fc_argmax_layer
    import fc_pkg::*;
#(
    parameter int ACT_W   = 8,
    parameter int WGT_W   = 8,
    parameter int BIAS_W  = 16,
    parameter int LANES   = 16,
    parameter int N_IN    = 256,
    parameter int N_OUT   = 10,
    parameter int ACC_W   = 32,
    parameter int LABEL_W = 8
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [LANES*ACT_W-1:0]   a_Data_TDATA,
    input  logic                     a_Data_TVALID,
    output logic                     a_Data_TREADY,
    input  logic [BIAS_W-1:0]        weight_TDATA,
    input  logic                     weight_TVALID,
    output logic                     weight_TREADY,
    input  logic                     reload_req,
    output logic [LABEL_W-1:0]       pre_label_TDATA,
    output logic                     pre_label_TVALID,
    input  logic                     pre_label_TREADY,
    output logic [ACC_W-1:0]         pre_score_out,
    output logic                     weights_loaded
);

    localparam int BEATS   = calcBeats(N_IN, LANES);
    localparam int NWORDS  = N_OUT * BEATS;
    localparam int CLEN    = NWORDS + 3;
    localparam int AW      = addrWidth(NWORDS);
    localparam int CW      = addrWidth(CLEN);
    localparam int BW      = addrWidth(BEATS);
    localparam int OW      = addrWidth(N_OUT);
    localparam int LW      = addrWidth(LANES);
    localparam int WORD_W  = LANES * WGT_W;
    localparam int ABEAT_W = LANES * ACT_W;

    localparam logic [OW-1:0] LAST_CLASS = OW'(N_OUT - 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [LW-1:0] LAST_LANE  = LW'(LANES - 1);
    localparam logic [AW-1:0] LAST_WORD  = AW'(NWORDS - 1);
    localparam logic [CW-1:0] ISSUE_END  = CW'(NWORDS);
    localparam logic [CW-1:0] LAST_CYCLE = CW'(CLEN - 1);

    fc_state_e state_q, state_d;

    logic wRdy_q, wRdy_d;
    logic aRdy_q, aRdy_d;
    logic oValid_q, oValid_d;
    logic loaded_q, loaded_d;

    logic [OW-1:0]     biasCnt_q, biasCnt_d;
    logic [LW-1:0]     laneCnt_q, laneCnt_d;
    logic [AW-1:0]     wAddr_q, wAddr_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [BW-1:0]     colCnt_q, colCnt_d;
    logic [CW-1:0]     cmpCnt_q, cmpCnt_d;
    logic [BW-1:0]     issBeat_q, issBeat_d;
    logic [OW-1:0]     issClass_q, issClass_d;

    logic weightFire, actFire, resultFire, reloadNow;
    logic biasWe, wramWe, actWe, issue;

    logic [BIAS_W-1:0]  biasMem [N_OUT];
    logic [WORD_W-1:0]  wram [NWORDS];
    logic [ABEAT_W-1:0] actBuf_q [BEATS];

    logic [AW-1:0]            rdAddr;
    logic [WORD_W-1:0]        rdWord;
    logic signed [ACC_W-1:0]  macSum;

    logic v1_q, f1_q, l1_q, v2_q, f2_q, l2_q;
    logic [OW-1:0] c1_q, c2_q;

    logic [63:0]              biasWide;
    logic signed [ACC_W-1:0]  biasExt;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  best_q, best_d;
    logic [LABEL_W-1:0]       label_q, label_d;
    logic                     doneV_q, doneV_d;
    logic [OW-1:0]            doneClass_q, doneClass_d;

    logic unusedWeightBits;
    assign unusedWeightBits = ^weight_TDATA[BIAS_W-1:WGT_W];

    // A reload request in an idle COLLECT wins over an activation beat, so hold TREADY low then
    assign reloadNow     = aRdy_q && reload_req && (colCnt_q == '0);
    assign a_Data_TREADY = aRdy_q && !reloadNow;
    assign weight_TREADY = wRdy_q;

    assign weightFire = weight_TVALID && wRdy_q;
    assign actFire    = a_Data_TVALID && a_Data_TREADY;
    assign resultFire = oValid_q && pre_label_TREADY;

    assign pre_label_TVALID = oValid_q;
    assign pre_label_TDATA  = label_q;
    assign pre_score_out    = best_q;
    assign weights_loaded   = loaded_q;

    // Next-state, counter and write-enable logic for the load/collect/compute/output sequence
    always_comb begin
        state_d    = state_q;
        loaded_d   = loaded_q;
        biasCnt_d  = biasCnt_q;
        laneCnt_d  = laneCnt_q;
        wAddr_d    = wAddr_q;
        pack_d     = pack_q;
        colCnt_d   = colCnt_q;
        cmpCnt_d   = cmpCnt_q;
        issBeat_d  = issBeat_q;
        issClass_d = issClass_q;
        biasWe     = 1'b0;
        wramWe     = 1'b0;
        actWe      = 1'b0;
        issue      = 1'b0;
        case (state_q)
            LOAD_B: begin
                if (weightFire) begin
                    biasWe = 1'b1;
                    if (biasCnt_q == LAST_CLASS) begin
                        biasCnt_d = '0;
                        state_d   = LOAD_W;
                    end else begin
                        biasCnt_d = biasCnt_q + OW'(1);
                    end
                end
            end
            LOAD_W: begin
                if (weightFire) begin
                    pack_d = {weight_TDATA[WGT_W-1:0], pack_q[WORD_W-1:WGT_W]};
                    if (laneCnt_q == LAST_LANE) begin
                        laneCnt_d = '0;
                        wramWe    = 1'b1;
                        if (wAddr_q == LAST_WORD) begin
                            wAddr_d  = '0;
                            loaded_d = 1'b1;
                            state_d  = COLLECT;
                        end else begin
                            wAddr_d = wAddr_q + AW'(1);
                        end
                    end else begin
                        laneCnt_d = laneCnt_q + LW'(1);
                    end
                end
            end
            COLLECT: begin
                if (reloadNow) begin
                    loaded_d = 1'b0;
                    state_d  = LOAD_B;
                end else if (actFire) begin
                    actWe = 1'b1;
                    if (colCnt_q == LAST_BEAT) begin
                        colCnt_d   = '0;
                        cmpCnt_d   = '0;
                        issBeat_d  = '0;
                        issClass_d = '0;
                        state_d    = COMPUTE;
                    end else begin
                        colCnt_d = colCnt_q + BW'(1);
                    end
                end
            end
            COMPUTE: begin
                issue = (cmpCnt_q < ISSUE_END);
                if (issue) begin
                    if (issBeat_q == LAST_BEAT) begin
                        issBeat_d  = '0;
                        issClass_d = issClass_q + OW'(1);
                    end else begin
                        issBeat_d = issBeat_q + BW'(1);
                    end
                end
                if (cmpCnt_q == LAST_CYCLE) begin
                    cmpCnt_d = '0;
                    state_d  = OUTPUT;
                end else begin
                    cmpCnt_d = cmpCnt_q + CW'(1);
                end
            end
            OUTPUT: begin
                if (resultFire) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = LOAD_B;
            end
        endcase
        wRdy_d   = (state_d == LOAD_B) || (state_d == LOAD_W);
        aRdy_d   = (state_d == COLLECT);
        oValid_d = (state_d == OUTPUT);
    end

    // Control state, handshake flags and counters
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= LOAD_B;
            wRdy_q     <= 1'b0;
            aRdy_q     <= 1'b0;
            oValid_q   <= 1'b0;
            loaded_q   <= 1'b0;
            biasCnt_q  <= '0;
            laneCnt_q  <= '0;
            wAddr_q    <= '0;
            pack_q     <= '0;
            colCnt_q   <= '0;
            cmpCnt_q   <= '0;
            issBeat_q  <= '0;
            issClass_q <= '0;
        end else begin
            state_q    <= state_d;
            wRdy_q     <= wRdy_d;
            aRdy_q     <= aRdy_d;
            oValid_q   <= oValid_d;
            loaded_q   <= loaded_d;
            biasCnt_q  <= biasCnt_d;
            laneCnt_q  <= laneCnt_d;
            wAddr_q    <= wAddr_d;
            pack_q     <= pack_d;
            colCnt_q   <= colCnt_d;
            cmpCnt_q   <= cmpCnt_d;
            issBeat_q  <= issBeat_d;
            issClass_q <= issClass_d;
        end
    end

    // Bias and weight storage; contents survive reset so only a reload changes them
    always_ff @(posedge ap_clk) begin
        if (biasWe) begin
            biasMem[biasCnt_q] <= weight_TDATA;
        end
        if (wramWe) begin
            wram[wAddr_q] <= pack_d;
        end
    end

    // Activation buffer holding one full image
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < BEATS; i++) begin
                actBuf_q[i] <= '0;
            end
        end else if (actWe) begin
            actBuf_q[colCnt_q] <= a_Data_TDATA;
        end
    end

    // Word address follows the compute counter since words are stored class-major, beat-minor
    always_comb begin
        rdAddr = issue ? cmpCnt_q[AW-1:0] : '0;
    end

    assign rdWord = wram[rdAddr];

    fc_mac_lanes #(
        .LANES (LANES),
        .ACT_W (ACT_W),
        .WGT_W (WGT_W),
        .SUM_W (ACC_W)
    ) uMac (
        .clk_i  (ap_clk),
        .rst_ni (ap_rst_n),
        .act_i  (actBuf_q[issBeat_q]),
        .wgt_i  (rdWord),
        .sum_o  (macSum)
    );

    // Carry valid/first/last/class tags alongside the two MAC pipeline stages
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v1_q <= 1'b0;
            f1_q <= 1'b0;
            l1_q <= 1'b0;
            c1_q <= '0;
            v2_q <= 1'b0;
            f2_q <= 1'b0;
            l2_q <= 1'b0;
            c2_q <= '0;
        end else begin
            v1_q <= issue;
            f1_q <= (issBeat_q == '0);
            l1_q <= (issBeat_q == LAST_BEAT);
            c1_q <= issClass_q;
            v2_q <= v1_q;
            f2_q <= f1_q;
            l2_q <= l1_q;
            c2_q <= c1_q;
        end
    end

    assign biasWide = signExtend(64'(biasMem[c2_q]), BIAS_W);
    assign biasExt  = biasWide[ACC_W-1:0];

    // Accumulate each class (seeded by its bias) and keep the strictly-greatest finished class
    always_comb begin
        acc_d       = acc_q;
        doneV_d     = 1'b0;
        doneClass_d = doneClass_q;
        best_d      = best_q;
        label_d     = label_q;
        if (v2_q) begin
            acc_d       = (f2_q ? biasExt : acc_q) + macSum;
            doneV_d     = l2_q;
            doneClass_d = c2_q;
        end
        if (doneV_q && ((doneClass_q == '0) || (acc_q > best_q))) begin
            best_d  = acc_q;
            label_d = LABEL_W'(doneClass_q);
        end
    end

    // Accumulator and argmax result registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q       <= '0;
            doneV_q     <= 1'b0;
            doneClass_q <= '0;
            best_q      <= '0;
            label_q     <= '0;
        end else begin
            acc_q       <= acc_d;
            doneV_q     <= doneV_d;
            doneClass_q <= doneClass_d;
            best_q      <= best_d;
            label_q     <= label_d;
        end
    end

endmodule

// File: tb/tb_fc_argmax_layer.sv
// Directed self-checking bench for fc_argmax_layer.
module tb_fc_argmax_layer;

    localparam int ACT_W   = 8;
    localparam int WGT_W   = 8;
    localparam int BIAS_W  = 16;
    localparam int LANES   = 16;
    localparam int N_IN    = 256;
    localparam int N_OUT   = 10;
    localparam int ACC_W   = 32;
    localparam int LABEL_W = 8;
    localparam int BEATS   = N_IN / LANES;
    localparam int COMPUTE_CYCLES = N_OUT * BEATS + 3;

    logic                   ap_clk;
    logic                   ap_rst_n;
    logic [LANES*ACT_W-1:0] a_Data_TDATA;
    logic                   a_Data_TVALID;
    logic                   a_Data_TREADY;
    logic [BIAS_W-1:0]      weight_TDATA;
    logic                   weight_TVALID;
    logic                   weight_TREADY;
    logic                   reload_req;
    logic [LABEL_W-1:0]     pre_label_TDATA;
    logic                   pre_label_TVALID;
    logic                   pre_label_TREADY;
    logic [ACC_W-1:0]       pre_score_out;
    logic                   weights_loaded;

    int checks = 0;
    int errors = 0;
    int biasTab [N_OUT];
    int wgtTab [N_OUT];

    fc_argmax_layer #(
        .ACT_W   (ACT_W),
        .WGT_W   (WGT_W),
        .BIAS_W  (BIAS_W),
        .LANES   (LANES),
        .N_IN    (N_IN),
        .N_OUT   (N_OUT),
        .ACC_W   (ACC_W),
        .LABEL_W (LABEL_W)
    ) dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .a_Data_TDATA     (a_Data_TDATA),
        .a_Data_TVALID    (a_Data_TVALID),
        .a_Data_TREADY    (a_Data_TREADY),
        .weight_TDATA     (weight_TDATA),
        .weight_TVALID    (weight_TVALID),
        .weight_TREADY    (weight_TREADY),
        .reload_req       (reload_req),
        .pre_label_TDATA  (pre_label_TDATA),
        .pre_label_TVALID (pre_label_TVALID),
        .pre_label_TREADY (pre_label_TREADY),
        .pre_score_out    (pre_score_out),
        .weights_loaded   (weights_loaded)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Hard stop in case something hangs outside a bounded wait
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic sendWeightBeat(input int value, output bit ok);
        int guard;
        weight_TDATA  = BIAS_W'(value);
        weight_TVALID = 1'b1;
        guard = 0;
        @(posedge ap_clk);
        while (!weight_TREADY && guard < 50) begin
            @(posedge ap_clk);
            guard++;
        end
        ok = (guard < 50);
        #1;
    endtask

    task automatic loadSet();
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < N_OUT && ok; k++) begin
            sendWeightBeat(biasTab[k], ok);
        end
        for (int k = 0; k < N_OUT && ok; k++) begin
            for (int f = 0; f < N_IN && ok; f++) begin
                sendWeightBeat(wgtTab[k], ok);
            end
        end
        weight_TVALID = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL weight_load: handshake timed out, required weight_TREADY");
        end
    endtask

    task automatic requestReload();
        reload_req = 1'b1;
        @(posedge ap_clk);
        #1;
        reload_req = 1'b0;
    endtask

    task automatic sendImage(input int value);
        logic [ACT_W-1:0] a8;
        int guard;
        bit ok;
        a8 = ACT_W'(value);
        a_Data_TDATA  = {LANES{a8}};
        a_Data_TVALID = 1'b1;
        ok = 1'b1;
        for (int b = 0; b < BEATS && ok; b++) begin
            guard = 0;
            @(posedge ap_clk);
            while (!a_Data_TREADY && guard < 50) begin
                @(posedge ap_clk);
                guard++;
            end
            ok = (guard < 50);
            #1;
        end
        a_Data_TVALID = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL act_send: handshake timed out, required a_Data_TREADY");
        end
    endtask

    task automatic waitResult(output int cycles);
        cycles = 0;
        while (!pre_label_TVALID && cycles < 2000) begin
            @(posedge ap_clk);
            #1;
            cycles++;
        end
    endtask

    task automatic consumeResult();
        pre_label_TREADY = 1'b1;
        @(posedge ap_clk);
        #1;
        pre_label_TREADY = 1'b0;
    endtask

    task automatic applyStimulus(input int biasA, input int wgtA);
        for (int k = 0; k < N_OUT; k++) begin
            biasTab[k] = biasA;
            wgtTab[k]  = wgtA;
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        checks++;
        if ({weight_TREADY, a_Data_TREADY, pre_label_TVALID} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_handshake: got %b required 000", {weight_TREADY, a_Data_TREADY, pre_label_TVALID});
        end
        checks++;
        if (pre_label_TDATA !== '0 || pre_score_out !== '0 || weights_loaded !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: label %0d score %0d loaded %b required 0 0 0", pre_label_TDATA, pre_score_out, weights_loaded);
        end
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        checks++;
        if (weight_TREADY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_wready: got %b required 1", weight_TREADY);
        end
    endtask

    task automatic test_basic();
        int cycles;
        for (int k = 0; k < N_OUT; k++) begin
            biasTab[k] = k;
            wgtTab[k]  = 1;
        end
        loadSet();
        checks++;
        if (weights_loaded !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_loaded: got %b required 1", weights_loaded);
        end
        sendImage(1);
        waitResult(cycles);
        checks++;
        if (cycles !== COMPUTE_CYCLES) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d required %0d", cycles, COMPUTE_CYCLES);
        end
        checks++;
        if (pre_label_TDATA !== 8'd9) begin
            errors++;
            $display("[TB] FAIL basic_label: got %0d required 9", pre_label_TDATA);
        end
        checks++;
        if (pre_score_out !== 32'd265) begin
            errors++;
            $display("[TB] FAIL basic_score: got %0d required 265", pre_score_out);
        end
        consumeResult();
        checks++;
        if (pre_label_TVALID !== 1'b0 || a_Data_TREADY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_after_handshake: tvalid %b aready %b required 0 1", pre_label_TVALID, a_Data_TREADY);
        end
    endtask

    task automatic test_class3();
        int cycles;
        applyStimulus(0, 1);
        wgtTab[3] = 2;
        requestReload();
        loadSet();
        sendImage(1);
        waitResult(cycles);
        checks++;
        if (pre_label_TVALID !== 1'b1 || pre_label_TDATA !== 8'd3) begin
            errors++;
            $display("[TB] FAIL class3_label: valid %b label %0d required 1 3", pre_label_TVALID, pre_label_TDATA);
        end
        checks++;
        if (pre_score_out !== 32'd512) begin
            errors++;
            $display("[TB] FAIL class3_score: got %0d required 512", pre_score_out);
        end
        consumeResult();
    endtask

    task automatic test_tie();
        int cycles;
        applyStimulus(0, 0);
        biasTab[2] = 5;
        biasTab[7] = 5;
        requestReload();
        loadSet();
        sendImage(1);
        waitResult(cycles);
        checks++;
        if (pre_label_TVALID !== 1'b1 || pre_label_TDATA !== 8'd2) begin
            errors++;
            $display("[TB] FAIL tie_label: valid %b label %0d required 1 2", pre_label_TVALID, pre_label_TDATA);
        end
        checks++;
        if (pre_score_out !== 32'd5) begin
            errors++;
            $display("[TB] FAIL tie_score: got %0d required 5", pre_score_out);
        end
        consumeResult();
    endtask

    task automatic test_negative();
        int cycles;
        applyStimulus(0, -1);
        wgtTab[0] = 1;
        requestReload();
        loadSet();
        sendImage(-1);
        waitResult(cycles);
        checks++;
        if (pre_label_TVALID !== 1'b1 || pre_label_TDATA !== 8'd1) begin
            errors++;
            $display("[TB] FAIL negative_label: valid %b label %0d required 1 1", pre_label_TVALID, pre_label_TDATA);
        end
        checks++;
        if (pre_score_out !== 32'h00000100) begin
            errors++;
            $display("[TB] FAIL negative_score: got 0x%08h required 0x00000100", pre_score_out);
        end
        consumeResult();
    endtask

    task automatic test_stall();
        int cycles;
        bit badValid, badLabel, badScore, badReady;
        badValid = 1'b0;
        badLabel = 1'b0;
        badScore = 1'b0;
        badReady = 1'b0;
        sendImage(-1);
        waitResult(cycles);
        for (int i = 0; i < 20; i++) begin
            if (pre_label_TVALID !== 1'b1) badValid = 1'b1;
            if (pre_label_TDATA !== 8'd1) badLabel = 1'b1;
            if (pre_score_out !== 32'd256) badScore = 1'b1;
            if (a_Data_TREADY !== 1'b0) badReady = 1'b1;
            @(posedge ap_clk);
            #1;
        end
        checks++;
        if (badValid) begin
            errors++;
            $display("[TB] FAIL stall_valid: tvalid dropped during stall, required 1");
        end
        checks++;
        if (badLabel || badScore) begin
            errors++;
            $display("[TB] FAIL stall_data: label %0d score %0d required 1 256 throughout", pre_label_TDATA, pre_score_out);
        end
        checks++;
        if (badReady) begin
            errors++;
            $display("[TB] FAIL stall_aready: a_Data_TREADY rose during stall, required 0");
        end
        consumeResult();
        sendImage(1);
        waitResult(cycles);
        checks++;
        if (pre_label_TVALID !== 1'b1 || pre_label_TDATA !== 8'd0 || pre_score_out !== 32'd256) begin
            errors++;
            $display("[TB] FAIL stall_next_image: valid %b label %0d score %0d required 1 0 256", pre_label_TVALID, pre_label_TDATA, pre_score_out);
        end
        consumeResult();
    endtask

    task automatic test_reload();
        int cycles;
        applyStimulus(0, 1);
        biasTab[4] = 100;
        requestReload();
        checks++;
        if (weights_loaded !== 1'b0 || weight_TREADY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reload_drop: loaded %b wready %b required 0 1", weights_loaded, weight_TREADY);
        end
        loadSet();
        checks++;
        if (weights_loaded !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reload_rise: got %b required 1", weights_loaded);
        end
        sendImage(1);
        waitResult(cycles);
        checks++;
        if (pre_label_TVALID !== 1'b1 || pre_label_TDATA !== 8'd4 || pre_score_out !== 32'd356) begin
            errors++;
            $display("[TB] FAIL reload_result: valid %b label %0d score %0d required 1 4 356", pre_label_TVALID, pre_label_TDATA, pre_score_out);
        end
        consumeResult();
    endtask

    task automatic test_reset_mid_compute();
        sendImage(1);
        repeat (40) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (pre_score_out !== '0 || pre_label_TDATA !== '0 || pre_label_TVALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_result: valid %b label %0d score %0d required 0 0 0", pre_label_TVALID, pre_label_TDATA, pre_score_out);
        end
        checks++;
        if ({weights_loaded, weight_TREADY, a_Data_TREADY} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL midreset_flags: got %b required 000", {weights_loaded, weight_TREADY, a_Data_TREADY});
        end
        #2;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        checks++;
        if (weight_TREADY !== 1'b1 || weights_loaded !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_release: wready %b loaded %b required 1 0", weight_TREADY, weights_loaded);
        end
        repeat (200) @(posedge ap_clk);
        #1;
        checks++;
        if (pre_label_TVALID !== 1'b0 || weight_TREADY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_idle: tvalid %b wready %b required 0 1", pre_label_TVALID, weight_TREADY);
        end
    endtask

    initial begin
        ap_rst_n         = 1'b0;
        a_Data_TDATA     = '0;
        a_Data_TVALID    = 1'b0;
        weight_TDATA     = '0;
        weight_TVALID    = 1'b0;
        reload_req       = 1'b0;
        pre_label_TREADY = 1'b0;
        test_reset();
        test_basic();
        test_class3();
        test_tie();
        test_negative();
        test_stall();
        test_reload();
        test_reset_mid_compute();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
